// File: rtl/aes_round_ctrl.sv
// AES encryption round sequencer: runs one block through the initial key add and NR
// rounds, fetching round keys on demand and driving an external combinational round datapath.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         in_ready,
  input  logic [0:127] plaintext,
  output logic         rk_req,
  output logic [3:0]   rk_idx,
  input  logic         rk_valid,
  input  logic [0:127] rk_data,
  output logic [0:127] dp_in,
  output logic         dp_final,
  input  logic [0:127] dp_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] ciphertext
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEY0  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LP_NR = 4'(NR);

  state_t       r_fsm;
  state_t       w_fsm_nxt;
  logic [3:0]   r_rnd;
  logic [3:0]   w_rnd_nxt;
  logic [0:127] r_data;
  logic [0:127] w_data_nxt;

  logic         r_in_ready;
  logic         r_rk_req;
  logic [3:0]   r_rk_idx;
  logic         r_dp_final;
  logic         r_out_valid;
  logic         w_in_ready_nxt;
  logic         w_rk_req_nxt;
  logic [3:0]   w_rk_idx_nxt;
  logic         w_dp_final_nxt;
  logic         w_out_valid_nxt;

  // Next state, state-register update and next-cycle output decode
  always_comb begin
    w_fsm_nxt       = r_fsm;
    w_rnd_nxt       = r_rnd;
    w_data_nxt      = r_data;
    w_in_ready_nxt  = 1'b0;
    w_rk_req_nxt    = 1'b0;
    w_rk_idx_nxt    = 4'd0;
    w_dp_final_nxt  = 1'b0;
    w_out_valid_nxt = 1'b0;

    case (r_fsm)
      IDLE: begin
        if (start) begin
          w_data_nxt = plaintext;
          w_rnd_nxt  = 4'd0;
          w_fsm_nxt  = KEY0;
        end else begin
          w_fsm_nxt = IDLE;
        end
      end
      KEY0: begin
        if (rk_valid) begin
          w_data_nxt = r_data ^ rk_data;
          w_rnd_nxt  = 4'd1;
          w_fsm_nxt  = ROUND;
        end else begin
          w_fsm_nxt = KEY0;
        end
      end
      ROUND: begin
        if (rk_valid) begin
          w_data_nxt = dp_out ^ rk_data;
          if (r_rnd == LP_NR) begin
            w_fsm_nxt = DONE;
          end else begin
            w_rnd_nxt = r_rnd + 4'd1;
          end
        end else begin
          w_fsm_nxt = ROUND;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_fsm_nxt = IDLE;
        end else begin
          w_fsm_nxt = DONE;
        end
      end
      default: begin
        w_fsm_nxt = IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from where the FSM is heading
    w_in_ready_nxt  = (w_fsm_nxt == IDLE);
    w_rk_req_nxt    = (w_fsm_nxt == KEY0) || (w_fsm_nxt == ROUND);
    w_out_valid_nxt = (w_fsm_nxt == DONE);
    if (w_fsm_nxt == ROUND) begin
      w_rk_idx_nxt   = w_rnd_nxt;
      w_dp_final_nxt = (w_rnd_nxt == LP_NR);
    end else begin
      w_rk_idx_nxt   = 4'd0;
      w_dp_final_nxt = 1'b0;
    end
  end

  // FSM, round counter, cipher state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= IDLE;
      r_rnd       <= 4'd0;
      r_data      <= 128'd0;
      r_in_ready  <= 1'b1;
      r_rk_req    <= 1'b0;
      r_rk_idx    <= 4'd0;
      r_dp_final  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_rnd       <= w_rnd_nxt;
      r_data      <= w_data_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_rk_req    <= w_rk_req_nxt;
      r_rk_idx    <= w_rk_idx_nxt;
      r_dp_final  <= w_dp_final_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign in_ready   = r_in_ready;
  assign rk_req     = r_rk_req;
  assign rk_idx     = r_rk_idx;
  assign dp_final   = r_dp_final;
  assign out_valid  = r_out_valid;
  assign dp_in      = r_data;
  assign ciphertext = r_data;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: AES-128 (NR=10) and AES-256 (NR=14) instances driven against a
// software AES model, key schedule and round datapath, with a per-cycle protocol model.
module tb_aes_round_ctrl;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT3    = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk;
  logic         rst_n;
  logic         start_a     [2];
  logic         in_ready_a  [2];
  logic         rk_req_a    [2];
  logic         rk_valid_a  [2];
  logic         dp_final_a  [2];
  logic         out_valid_a [2];
  logic         out_ready_a [2];
  logic [3:0]   rk_idx_a    [2];
  logic [127:0] pt_a        [2];
  logic [127:0] rk_data_a   [2];
  logic [127:0] dp_in_a     [2];
  logic [127:0] dp_out_a    [2];
  logic [127:0] ct_a        [2];

  logic [127:0] rks [2][16];
  logic [15:0]  stall_mask [2];
  int           stall_cnt  [2];
  int           m_mode [2];   // 0: waiting for start, 1: waiting for key m_k, 2: holding result
  int           m_k    [2];
  logic [127:0] m_val  [2];
  logic [3:0]   idx_q [$];
  logic         fin_q [$];
  int           n_chk = 0;
  int           n_fail = 0;

  aes_round_ctrl #(.NR(10)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .in_ready(in_ready_a[0]),
    .plaintext(pt_a[0]), .rk_req(rk_req_a[0]), .rk_idx(rk_idx_a[0]),
    .rk_valid(rk_valid_a[0]), .rk_data(rk_data_a[0]), .dp_in(dp_in_a[0]),
    .dp_final(dp_final_a[0]), .dp_out(dp_out_a[0]), .out_valid(out_valid_a[0]),
    .out_ready(out_ready_a[0]), .ciphertext(ct_a[0])
  );

  aes_round_ctrl #(.NR(14)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .in_ready(in_ready_a[1]),
    .plaintext(pt_a[1]), .rk_req(rk_req_a[1]), .rk_idx(rk_idx_a[1]),
    .rk_valid(rk_valid_a[1]), .rk_data(rk_data_a[1]), .dp_in(dp_in_a[1]),
    .dp_final(dp_final_a[1]), .dp_out(dp_out_a[1]), .out_valid(out_valid_a[1]),
    .out_ready(out_ready_a[1]), .ciphertext(ct_a[1])
  );

  function automatic int nr_of(input int i);
    return (i == 0) ? 10 : 14;
  endfunction

  function automatic logic [7:0] gmul_f(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box from its definition: inverse x^254 in GF(2^8) followed by the affine map
  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] t = x;
    logic [7:0] r = 8'h01;
    for (int n = 0; n < 7; n++) begin
      t = gmul_f(t, t);
      r = gmul_f(r, t);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round_f(input logic [127:0] s, input logic fin);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int k = 0; k < 16; k++) b[k] = sbox_f(s[127-8*k -: 8]);
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++) t[4*j+i] = b[4*((j+i)%4)+i];
    if (!fin) begin
      for (int j = 0; j < 4; j++) begin
        a0 = t[4*j]; a1 = t[4*j+1]; a2 = t[4*j+2]; a3 = t[4*j+3];
        t[4*j]   = gmul_f(a0, 8'h02) ^ gmul_f(a1, 8'h03) ^ a2 ^ a3;
        t[4*j+1] = a0 ^ gmul_f(a1, 8'h02) ^ gmul_f(a2, 8'h03) ^ a3;
        t[4*j+2] = a0 ^ a1 ^ gmul_f(a2, 8'h02) ^ gmul_f(a3, 8'h03);
        t[4*j+3] = gmul_f(a0, 8'h03) ^ a1 ^ a2 ^ gmul_f(a3, 8'h02);
      end
    end
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = t[k];
    return r;
  endfunction

  task automatic expand_key(input int i, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    int          nr = nk + 6;
    for (int k = 0; k < 4*(nr+1); k++) begin
      if (k < nk) begin
        w[k] = key[255-32*k -: 32];
      end else begin
        t = w[k-1];
        if (k % nk == 0) begin
          t = {sbox_f(t[23:16]), sbox_f(t[15:8]), sbox_f(t[7:0]), sbox_f(t[31:24])} ^ {rcon, 24'h0};
          rcon = gmul_f(rcon, 8'h02);
        end else if (nk > 6 && k % nk == 4) begin
          t = {sbox_f(t[31:24]), sbox_f(t[23:16]), sbox_f(t[15:8]), sbox_f(t[7:0])};
        end
        w[k] = w[k-nk] ^ t;
      end
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) rks[i][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         rks[i][r] = 128'h0;
    end
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input int i);
    chk($sformatf("d%0d_rst_in_ready", i), 128'(in_ready_a[i]), 128'd1);
    chk($sformatf("d%0d_rst_rk_req", i), 128'(rk_req_a[i]), 128'd0);
    chk($sformatf("d%0d_rst_rk_idx", i), 128'(rk_idx_a[i]), 128'd0);
    chk($sformatf("d%0d_rst_dp_final", i), 128'(dp_final_a[i]), 128'd0);
    chk($sformatf("d%0d_rst_out_valid", i), 128'(out_valid_a[i]), 128'd0);
    chk($sformatf("d%0d_rst_ciphertext", i), ct_a[i], 128'd0);
    chk($sformatf("d%0d_rst_dp_in", i), dp_in_a[i], 128'd0);
  endtask

  // Key supplier with per-index stall injection, and the model round datapath
  for (genvar g = 0; g < 2; g++) begin : g_resp
    assign rk_valid_a[g] = rk_req_a[g] && !(stall_mask[g][rk_idx_a[g]] && (stall_cnt[g] < 3));
    assign rk_data_a[g]  = rks[g][rk_idx_a[g]];
    assign dp_out_a[g]   = aes_round_f(dp_in_a[g], dp_final_a[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt[0] <= 0;
      stall_cnt[1] <= 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (rk_req_a[i] && !rk_valid_a[i]) stall_cnt[i] <= stall_cnt[i] + 1;
        else if (rk_req_a[i])              stall_cnt[i] <= 0;
      end
    end
  end

  // Reference model: cipher state after each consumed key, computed with the software round
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] <= 0;
        m_k[i]    <= 0;
        m_val[i]  <= 128'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_mode[i] == 0) begin
          if (start_a[i]) begin
            m_val[i]  <= pt_a[i];
            m_k[i]    <= 0;
            m_mode[i] <= 1;
          end
        end else if (m_mode[i] == 1) begin
          if (rk_valid_a[i]) begin
            if (m_k[i] == 0) m_val[i] <= m_val[i] ^ rks[i][0];
            else m_val[i] <= aes_round_f(m_val[i], m_k[i] == nr_of(i)) ^ rks[i][m_k[i]];
            if (m_k[i] == nr_of(i)) m_mode[i] <= 2;
            else                    m_k[i]    <= m_k[i] + 1;
            if (i == 1) begin
              idx_q.push_back(rk_idx_a[1]);
              fin_q.push_back(dp_final_a[1]);
            end
          end
        end else begin
          if (out_ready_a[i]) m_mode[i] <= 0;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_in_ready", i), 128'(in_ready_a[i]), 128'(m_mode[i] == 0));
      chk($sformatf("d%0d_rk_req", i), 128'(rk_req_a[i]), 128'(m_mode[i] == 1));
      chk($sformatf("d%0d_out_valid", i), 128'(out_valid_a[i]), 128'(m_mode[i] == 2));
      chk($sformatf("d%0d_dp_final", i), 128'(dp_final_a[i]),
          128'((m_mode[i] == 1) && (m_k[i] == nr_of(i))));
      chk($sformatf("d%0d_dp_in", i), dp_in_a[i], m_val[i]);
      chk($sformatf("d%0d_ciphertext", i), ct_a[i], m_val[i]);
      if (m_mode[i] == 1) chk($sformatf("d%0d_rk_idx", i), 128'(rk_idx_a[i]), 128'(m_k[i]));
    end
  end

  // inj_kind 1: pulse start with other plaintext at rk_idx inj_idx; 2: pulse reset there
  task automatic run_block(input int i, input logic [15:0] smask, input int rdly,
                           input int inj_kind, input int inj_idx,
                           input logic [127:0] exp_ct, input int exp_lat);
    int cyc = 0;
    bit injd = 1'b0;
    @(negedge clk);
    stall_mask[i] = smask;
    pt_a[i]       = PT;
    start_a[i]    = 1'b1;
    @(negedge clk);
    start_a[i] = 1'b0;
    cyc = 1;
    while (!out_valid_a[i] && cyc < 200) begin
      if (inj_kind == 1 && !injd && rk_req_a[i] && rk_idx_a[i] == 4'(inj_idx)) begin
        injd       = 1'b1;
        pt_a[i]    = ~PT;
        start_a[i] = 1'b1;
      end else if (inj_kind == 2 && !injd && rk_req_a[i] && rk_idx_a[i] == 4'(inj_idx)) begin
        #2 rst_n = 1'b0;
        #1 chk_reset(i);
        @(negedge clk);
        #2 rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      start_a[i] = 1'b0;
      pt_a[i]    = PT;
      cyc++;
    end
    chk($sformatf("d%0d_latency", i), 128'(cyc), 128'(exp_lat));
    chk($sformatf("d%0d_result", i), ct_a[i], exp_ct);
    for (int k = 0; k < rdly; k++) begin
      chk($sformatf("d%0d_hold_ct", i), ct_a[i], exp_ct);
      chk($sformatf("d%0d_hold_in_ready", i), 128'(in_ready_a[i]), 128'd0);
      chk($sformatf("d%0d_hold_out_valid", i), 128'(out_valid_a[i]), 128'd1);
      @(negedge clk);
    end
    out_ready_a[i] = 1'b1;
    @(negedge clk);
    out_ready_a[i] = 1'b0;
    chk($sformatf("d%0d_back_idle", i), 128'(in_ready_a[i]), 128'd1);
    chk($sformatf("d%0d_ov_cleared", i), 128'(out_valid_a[i]), 128'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_a[i]     = 1'b0;
      out_ready_a[i] = 1'b0;
      pt_a[i]        = 128'h0;
      stall_mask[i]  = 16'h0;
    end
    expand_key(0, KEY128, 4);
    expand_key(1, KEY256, 8);
    #1 rst_n = 1'b0;
    #1 chk_reset(0);
    chk_reset(1);

    chk("c1_rk1", rks[0][1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    chk("c1_rk10", rks[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("c1_r1_start", PT ^ rks[0][0], 128'h00102030405060708090a0b0c0d0e0f0);
    chk("c3_rk1", rks[1][1], 128'h101112131415161718191a1b1c1d1e1f);
    chk("c3_rk2", rks[1][2], 128'ha573c29fa176c498a97fce93a572c09c);

    @(negedge clk);
    #2 rst_n = 1'b1;

    run_block(0, 16'h0000, 0, 0, 0, CT1, 12);   // plain C.1
    run_block(0, 16'h0421, 0, 0, 0, CT1, 21);   // 3-cycle stalls on keys 0, 5, 10
    run_block(0, 16'h0000, 5, 0, 0, CT1, 12);   // consumer back-pressure
    run_block(0, 16'h0000, 0, 1, 4, CT1, 12);   // start ignored mid-block
    run_block(0, 16'h0000, 0, 2, 6, CT1, 12);   // reset mid-block
    run_block(0, 16'h0000, 0, 0, 0, CT1, 12);   // clean run after reset

    idx_q.delete();
    fin_q.delete();
    run_block(1, 16'h0000, 0, 0, 0, CT3, 16);   // AES-256 C.3
    chk("d1_key_count", 128'(idx_q.size()), 128'd15);
    for (int k = 0; k < idx_q.size(); k++) begin
      chk($sformatf("d1_key_seq_%0d", k), 128'(idx_q[k]), 128'(k));
      chk($sformatf("d1_final_flag_%0d", k), 128'(fin_q[k]), 128'(k == 14));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
